// File: rtl/bip_mem_pkg.sv
// Shared types and default sizes for the BIP data memory.
package bip_mem_pkg;

  localparam int DMEM_WIDTH = 16;
  localparam int DMEM_DEPTH = 2048;

  // Dump engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/bip_data_memory_if.sv
// Bus bundle for bip_data_memory: CPU read/write port plus the dump stream.
// master = CPU / debug side, slave = the memory.
interface bip_data_memory_if
  import bip_mem_pkg::*;
#(
  parameter int WIDTH = DMEM_WIDTH,
  parameter int DEPTH = DMEM_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wr_en;
  logic [WIDTH-1:0]  cpu_wr_data;
  logic              cpu_rd_en;
  logic [WIDTH-1:0]  cpu_rd_data;

  logic              dump_start;
  logic [ADDR_W-1:0] dump_last;
  logic              dump_busy;
  logic [ADDR_W-1:0] dump_addr;
  logic [WIDTH-1:0]  dump_data;
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_done;

  modport master (
    output cpu_addr, cpu_wr_en, cpu_wr_data, cpu_rd_en,
    output dump_start, dump_last, dump_ready,
    input  cpu_rd_data, dump_busy, dump_addr, dump_data, dump_valid, dump_done
  );

  modport slave (
    input  cpu_addr, cpu_wr_en, cpu_wr_data, cpu_rd_en,
    input  dump_start, dump_last, dump_ready,
    output cpu_rd_data, dump_busy, dump_addr, dump_data, dump_valid, dump_done
  );
endinterface

// File: rtl/bip_dpram.sv
// Inferred true dual-port RAM with registered outputs.
// Port A: read/write (CPU). Port B: read-only (dump), always read-first.
// Define DMEM_WRITE_FIRST_EN to make a same-cycle read+write on port A
// return the newly written word; otherwise port A is read-first.
module bip_dpram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic                     a_wr_en,
  input  logic [WIDTH-1:0]         a_wr_data,
  input  logic                     a_rd_en,
  output logic [WIDTH-1:0]         a_rd_data,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic                     b_rd_en,
  output logic [WIDTH-1:0]         b_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a_rd_d, a_rd_q;
  logic [WIDTH-1:0] b_rd_d, b_rd_q;

  // Storage write from port A.
  // NOTE: the array is deliberately not reset so it maps onto block RAM; only the output registers reset.
  always_ff @(posedge clk) begin
    if (a_wr_en) mem[a_addr] <= a_wr_data;
  end

  // Port A read data select; holds the last value when not reading.
  // NOTE: default assignment first so every path drives a_rd_d and no latch is inferred.
  always_comb begin
    a_rd_d = a_rd_q;
    if (a_rd_en) begin
`ifdef DMEM_WRITE_FIRST_EN
      a_rd_d = a_wr_en ? a_wr_data : mem[a_addr];
`else
      a_rd_d = mem[a_addr];
`endif
    end
  end

  // Port B read data select; sees the array before this edge's write.
  always_comb begin
    b_rd_d = b_rd_q;
    if (b_rd_en) b_rd_d = mem[b_addr];
  end

  // Output registers.
  // NOTE: non-blocking assignments on state so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      a_rd_q <= a_rd_d;
      b_rd_q <= b_rd_d;
    end
  end

  assign a_rd_data = a_rd_q;
  assign b_rd_data = b_rd_q;

endmodule

// File: rtl/bip_data_memory.sv
// BIP data memory: CPU port plus a dump engine that streams words
// 0..dump_last over a valid/ready handshake. Port A behaviour for
// same-cycle read+write is selected by DMEM_WRITE_FIRST_EN (see bip_dpram).
module bip_data_memory
  import bip_mem_pkg::*;
#(
  parameter int WIDTH = DMEM_WIDTH,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  bip_data_memory_if.slave   bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              b_rd_en;

  bip_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .a_addr    (bus.cpu_addr),
    .a_wr_en   (bus.cpu_wr_en),
    .a_wr_data (bus.cpu_wr_data),
    .a_rd_en   (bus.cpu_rd_en),
    .a_rd_data (bus.cpu_rd_data),
    .b_addr    (addr_q),
    .b_rd_en   (b_rd_en),
    .b_rd_data (bus.dump_data)
  );

  // Dump state, address counter and latched last address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: one READ/HOLD pair per word, stop after last_q is accepted.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          last_d  = bus.dump_last;
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ: state_d = HOLD;
      HOLD: begin
        if (bus.dump_ready) begin
          if (addr_q == last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    b_rd_en        = (state_q == READ);
    bus.dump_busy  = (state_q != IDLE);
    bus.dump_valid = (state_q == HOLD);
    bus.dump_done  = (state_q == DONE);
    bus.dump_addr  = addr_q;
  end

endmodule

// File: tb/tb_bip_data_memory.sv
// Self-checking bench for bip_data_memory: an array model of the storage,
// directed cases and randomized CPU traffic / dump backpressure.
module tb_bip_data_memory;
  import bip_mem_pkg::*;

  localparam int W  = DMEM_WIDTH;
  localparam int D  = DMEM_DEPTH;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bip_data_memory_if #(.WIDTH(W), .DEPTH(D)) bus ();

  bip_data_memory #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] model [D];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int a, input logic [W-1:0] d);
    bus.cpu_addr    = AW'(a);
    bus.cpu_wr_data = d;
    bus.cpu_wr_en   = 1'b1;
    tick();
    bus.cpu_wr_en   = 1'b0;
    model[a]        = d;
  endtask

  task automatic cpu_read_check(input string tag, input int a);
    bus.cpu_addr  = AW'(a);
    bus.cpu_rd_en = 1'b1;
    tick();
    bus.cpu_rd_en = 1'b0;
    check(tag, bus.cpu_rd_data, model[a]);
  endtask

  // Dump 0..last; stall_len ready-low cycles on word stall_idx; rnd adds
  // random stalls, ignored dump_start pulses and CPU writes racing port B.
  task automatic run_dump(input int last, input int stall_idx, input int stall_len, input bit rnd);
    logic [W-1:0] exp;
    int n;
    bus.dump_last  = AW'(last);
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    bus.dump_last  = AW'($urandom);
    for (int idx = 0; idx <= last; idx++) begin
      check("read_valid", bus.dump_valid, 0);
      check("read_busy", bus.dump_busy, 1);
      exp = model[idx];
      if (rnd && $urandom_range(0, 1) == 1) begin
        bus.cpu_addr    = AW'(idx);
        bus.cpu_wr_data = W'($urandom);
        bus.cpu_wr_en   = 1'b1;
        model[idx]      = bus.cpu_wr_data;
      end
      tick();
      bus.cpu_wr_en = 1'b0;
      check("hold_valid", bus.dump_valid, 1);
      check("dump_addr", bus.dump_addr, idx);
      check("dump_data", bus.dump_data, exp);
      n = (idx == stall_idx) ? stall_len : (rnd ? int'($urandom_range(0, 3)) : 0);
      bus.dump_ready = 1'b0;
      for (int s = 0; s < n; s++) begin
        if (rnd) begin
          bus.dump_start = 1'b1;
          bus.dump_last  = AW'($urandom);
        end
        tick();
        bus.dump_start = 1'b0;
        check("stall_valid", bus.dump_valid, 1);
        check("stall_addr", bus.dump_addr, idx);
        check("stall_data", bus.dump_data, exp);
      end
      bus.dump_ready = 1'b1;
      tick();
      bus.dump_ready = 1'b0;
    end
    check("done_pulse", bus.dump_done, 1);
    check("done_valid", bus.dump_valid, 0);
    check("done_busy", bus.dump_busy, 1);
    bus.dump_start = 1'b1;
    bus.dump_last  = AW'($urandom);
    tick();
    bus.dump_start = 1'b0;
    check("done_clear", bus.dump_done, 0);
    check("idle_busy", bus.dump_busy, 0);
    check("idle_valid", bus.dump_valid, 0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int a;
    int op;

    reset           = 1'b1;
    bus.cpu_addr    = '0;
    bus.cpu_wr_en   = 1'b0;
    bus.cpu_wr_data = '0;
    bus.cpu_rd_en   = 1'b0;
    bus.dump_start  = 1'b0;
    bus.dump_last   = '0;
    bus.dump_ready  = 1'b0;
    tick();
    tick();
    check("rst_cpu_rd_data", bus.cpu_rd_data, 0);
    check("rst_busy", bus.dump_busy, 0);
    check("rst_valid", bus.dump_valid, 0);
    check("rst_done", bus.dump_done, 0);
    check("rst_addr", bus.dump_addr, 0);
    check("rst_data", bus.dump_data, 0);
    reset = 1'b0;

    // Give every word a known value so any dump range is checkable.
    for (int i = 0; i < D; i++) cpu_write(i, W'($urandom));

    // Basic write/read and hold.
    cpu_write(5, 16'hBEEF);
    bus.cpu_addr  = AW'(5);
    bus.cpu_rd_en = 1'b1;
    tick();
    bus.cpu_rd_en = 1'b0;
    check("rd5", bus.cpu_rd_data, 16'hBEEF);
    bus.cpu_addr = AW'(9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd5_hold", bus.cpu_rd_data, 16'hBEEF);
    end

    // Same-cycle read and write on port A.
    cpu_write(7, 16'hAAAA);
    bus.cpu_addr    = AW'(7);
    bus.cpu_wr_data = 16'h1234;
    bus.cpu_wr_en   = 1'b1;
    bus.cpu_rd_en   = 1'b1;
    tick();
    bus.cpu_wr_en   = 1'b0;
    bus.cpu_rd_en   = 1'b0;
`ifdef DMEM_WRITE_FIRST_EN
    check("rw7_same_cycle", bus.cpu_rd_data, 16'h1234);
`else
    check("rw7_same_cycle", bus.cpu_rd_data, 16'hAAAA);
`endif
    model[7] = 16'h1234;
    cpu_read_check("rd7_after", 7);

    // Random CPU traffic on a small window to get address reuse.
    for (int i = 0; i < 300; i++) begin
      a  = int'($urandom_range(0, 31));
      op = int'($urandom_range(0, 2));
      d  = W'($urandom);
      if (op == 0) begin
        cpu_write(a, d);
      end else if (op == 1) begin
        cpu_read_check("rand_rd", a);
      end else begin
`ifdef DMEM_WRITE_FIRST_EN
        exp = d;
`else
        exp = model[a];
`endif
        bus.cpu_addr    = AW'(a);
        bus.cpu_wr_data = d;
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_rd_en   = 1'b1;
        tick();
        bus.cpu_wr_en   = 1'b0;
        bus.cpu_rd_en   = 1'b0;
        model[a]        = d;
        check("rand_rw", bus.cpu_rd_data, exp);
      end
    end

    // Directed dumps.
    for (int i = 0; i < 4; i++) cpu_write(i, W'(16'h10 + i));
    run_dump(3, -1, 0, 1'b0);
    run_dump(3, 1, 5, 1'b0);
    run_dump(0, -1, 0, 1'b0);
    run_dump(D - 1, -1, 0, 1'b0);

    // Randomized dumps with backpressure and racing CPU writes.
    for (int r = 0; r < 4; r++) run_dump(int'($urandom_range(1, 40)), -1, 0, 1'b1);

    // Reset during the third HOLD.
    bus.dump_last  = AW'(5);
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.dump_ready = 1'b1;
      tick();
      bus.dump_ready = 1'b0;
      tick();
    end
    check("third_hold_valid", bus.dump_valid, 1);
    check("third_hold_addr", bus.dump_addr, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cpu_rd_data", bus.cpu_rd_data, 0);
    check("mid_rst_busy", bus.dump_busy, 0);
    check("mid_rst_valid", bus.dump_valid, 0);
    check("mid_rst_done", bus.dump_done, 0);
    check("mid_rst_addr", bus.dump_addr, 0);
    check("mid_rst_data", bus.dump_data, 0);
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_done", bus.dump_done, 0);
      check("post_rst_idle", bus.dump_busy, 0);
    end
    bus.dump_ready = 1'b0;
    run_dump(3, -1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_data_memory.md
# bip_data_memory

Parametrised data memory for the BIP datapath, generalising the fixed 16-bit × 2048-word memory to arbitrary width and depth. A CPU read/write port serves the processor. An independent dump engine streams a contiguous address range out through a valid/ready handshake to the UART debug unit. The dump can run while the CPU is halted or running.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 2048, number of words; power of two, ≥ 2
- ADDR_W (localparam), $clog2(DEPTH), address width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wr_en  in  1  write cpu_wr_data to cpu_addr this cycle
- cpu_wr_data  in  WIDTH  write data
- cpu_rd_en  in  1  read cpu_addr this cycle
- cpu_rd_data  out  WIDTH  registered read data
- dump_start  in  1  one-cycle pulse; starts a dump from address 0
- dump_last  in  ADDR_W  last address to dump; sampled with dump_start
- dump_busy  out  1  dump in progress
- dump_addr  out  ADDR_W  address of the word on dump_data
- dump_data  out  WIDTH  dumped word
- dump_valid  out  1  dump_data/dump_addr valid
- dump_ready  in  1  consumer accepts the word when valid & ready
- dump_done  out  1  one-cycle pulse after the final word is accepted

## Operation
- Storage: true dual-port RAM. Port A belongs to the CPU (read/write). Port B belongs to the dump engine (read-only). Contents are not cleared by reset.
- CPU port: write occurs on the edge with cpu_wr_en=1. cpu_rd_data updates only when cpu_rd_en=1 and otherwise holds its value.
- Port-B read of an address the CPU writes in the same cycle returns the old contents (read-first).
- Dump FSM states:
  - IDLE: dump_start=1 → latch dump_last, addr←0, go to READ.
  - READ: present addr to port B, go to HOLD.
  - HOLD: dump_valid=1; dump_data and dump_addr are stable. On valid & ready: if addr==last_latched, go to DONE; else addr←addr+1 and go to READ.
  - DONE: dump_done=1 for one cycle, then IDLE.
- dump_start is ignored unless the FSM is in IDLE (including during DONE).
- dump_last=0 dumps exactly one word. dump_last=DEPTH-1 dumps all words; the address never wraps.
- Reset mid-dump: the FSM returns to IDLE immediately, and no dump_done is issued.

## Timing
- Reset values: cpu_rd_data=0, dump_busy=0, dump_valid=0, dump_done=0, dump_addr=0, dump_data=0, state IDLE.
- CPU read latency: 1 cycle (address at edge n, data visible after edge n).
- Dump: dump_start sampled at edge t. READ during cycle t+1. dump_valid first high in cycle t+2.
- After an accepted transfer at edge k:
  - non-final word: next dump_valid is high in cycle k+2, giving a peak rate of 1 word per 2 cycles;
  - final word: dump_done is high in cycle k+1.
- dump_busy is high from cycle t+1 through the DONE cycle inclusive.
- dump_valid never drops without a handshake. dump_data and dump_addr do not change while valid & !ready.

## Configuration
- DMEM_WRITE_FIRST_EN defined: a CPU read and write to the same cycle on port A returns the new data (cpu_rd_data=cpu_wr_data).
- Undefined: the same access returns the old stored word (read-first).
- The macro affects port A only; port B is always read-first.

## Structure
- Package bip_mem_pkg holds:
  - dump state enum (IDLE, READ, HOLD, DONE);
  - default constants DMEM_WIDTH=16 and DMEM_DEPTH=2048.
- Sub-module bip_dpram is the inferred true dual-port RAM, carrying the DMEM_WRITE_FIRST_EN variant on port A.
- The dump FSM and address counter live in bip_data_memory.

## Test plan
- Write 0xBEEF to address 5, then read address 5 → cpu_rd_data=0xBEEF one cycle after the read; it holds when cpu_rd_en=0.
- Same-cycle write 0x1234 and read to address 7, which holds 0xAAAA → 0x1234 with DMEM_WRITE_FIRST_EN, 0xAAAA without.
- Preload addresses 0..3 with 0x10..0x13, dump_last=3, dump_ready held high → four transfers with dump_addr 0..3 and dump_data 0x10..0x13. First dump_valid appears 2 cycles after start; dump_done pulses 1 cycle after the last handshake.
- dump_ready low for 5 cycles on the second word → dump_valid stays high and dump_data stays 0x11 throughout; no word is skipped or duplicated.
- dump_last=0 → exactly one word (addr 0) followed by dump_done. dump_last=DEPTH-1 → DEPTH words with no wrap to address 0.
- Assert reset during the third HOLD → all outputs return to reset values next cycle, dump_done is never asserted, and a new dump_start restarts from address 0.
